// File: rtl/lcd_fmt_pkg.sv
// -----------------------------------------------------------------------------
// lcd_fmt_pkg
//   Constants and types shared by the decimal LCD formatter.
//   - ASCII_*    : characters used to build the display field
//   - fmtState_t : formatter sequencer states
// -----------------------------------------------------------------------------
package lcd_fmt_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } fmtState_t;

endpackage : lcd_fmt_pkg

// File: rtl/lcd_dec_formatter_dd_bcd_step.sv
// -----------------------------------------------------------------------------
// dd_bcd_step
//   One combinational double-dabble iteration. Every BCD nibble >= 5 gets +3,
//   then {bcd, mag} is shifted left by one bit, moving the next binary MSB
//   into the BCD LSB.
//   Ports:
//     bcdIn  / bcdOut : packed BCD digits, digit 0 in the low nibble
//     magIn  / magOut : remaining binary magnitude, consumed MSB first
// -----------------------------------------------------------------------------
module dd_bcd_step #(
  parameter int WIDTH  = 18,
  parameter int DIGITS = 6
) (
  input  logic [4*DIGITS-1:0] bcdIn,
  input  logic [WIDTH-1:0]    magIn,
  output logic [4*DIGITS-1:0] bcdOut,
  output logic [WIDTH-1:0]    magOut
);

  logic [4*DIGITS+WIDTH-1:0] work;

  // NOTE: every variable written in always_comb is assigned first, so no path
  // leaves it holding a previous value and no latch is inferred.
  always_comb begin
    work = {bcdIn, magIn};
    for (int i = 0; i < DIGITS; i++) begin
      if (work[WIDTH + 4*i +: 4] >= 4'd5) begin
        work[WIDTH + 4*i +: 4] = work[WIDTH + 4*i +: 4] + 4'd3;
      end
    end
  end

  // The top nibble never exceeds 4 for legal WIDTH/DIGITS, so the bit shifted
  // out of the BCD field is always zero.
  assign {bcdOut, magOut} = work << 1;

endmodule : dd_bcd_step

// File: rtl/lcd_dec_formatter.sv
// -----------------------------------------------------------------------------
// lcd_dec_formatter
//   Converts a WIDTH-bit ALU result into a DIGITS+1 character decimal ASCII
//   field (sign column + right-aligned magnitude) and streams it to the LCD
//   driver over a valid/ready handshake.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     start           : conversion request, honoured only in IDLE
//     dataIn          : operand, captured with start
//     signedMode      : 1 = dataIn is two's complement
//     charOut         : ASCII character to LCD_Driver
//     charValid       : charOut is valid
//     charReady       : LCD_Driver accepts charOut
//     busy            : job in progress (start accepted .. DONE)
//     done            : one-cycle pulse after the last character is accepted
//   Requires 10**DIGITS > 2**WIDTH.
// -----------------------------------------------------------------------------
module lcd_dec_formatter
  import lcd_fmt_pkg::*;
#(
  parameter int WIDTH       = 18,
  parameter int DIGITS      = 6,
  parameter int BLANK_ZEROS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             signedMode,
  output logic [7:0]       charOut,
  output logic             charValid,
  input  logic             charReady,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int IDX_W = $clog2(DIGITS + 1);

  fmtState_t             state;
  logic                  negReg;
  logic [WIDTH-1:0]      mag;
  logic [4*DIGITS-1:0]   bcd;
  logic [CNT_W-1:0]      bitCnt;
  logic [IDX_W-1:0]      charIdx;

  logic                  inNeg;
  logic [WIDTH-1:0]      inMag;
  logic [4*DIGITS-1:0]   stepBcd;
  logic [WIDTH-1:0]      stepMag;
  logic [7:0]            charTable [DIGITS+1];

  // The most negative value negates to itself; read as unsigned it is the
  // correct magnitude (2**(WIDTH-1)).
  assign inNeg = signedMode & dataIn[WIDTH-1];
  assign inMag = inNeg ? WIDTH'(~dataIn + 1'b1) : dataIn;

  dd_bcd_step #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_step (
    .bcdIn  (bcd),
    .magIn  (mag),
    .bcdOut (stepBcd),
    .magOut (stepMag)
  );

  // Character for every field position, derived from the finished BCD value.
  // A digit is blanked while all more significant digits are zero; the units
  // digit is always printed so zero shows as "0".
  always_comb begin
    logic       leading;
    logic [3:0] digit;
    leading      = 1'b1;
    digit        = 4'd0;
    charTable[0] = negReg ? ASCII_MINUS : ASCII_SPACE;
    for (int k = 1; k <= DIGITS; k++) begin
      digit   = bcd[4*(DIGITS-k) +: 4];
      leading = leading & (digit == 4'd0);
      if ((BLANK_ZEROS != 0) && leading && (k != DIGITS)) begin
        charTable[k] = ASCII_SPACE;
      end else begin
        charTable[k] = ASCII_ZERO + {4'd0, digit};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and simulation matches the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset along with control so the
      // post-reset state is fully defined, not left to power-up values.
      state     <= IDLE;
      negReg    <= 1'b0;
      mag       <= '0;
      bcd       <= '0;
      bitCnt    <= '0;
      charIdx   <= '0;
      charOut   <= ASCII_SPACE;
      charValid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            negReg <= inNeg;
            mag    <= inMag;
            bcd    <= '0;
            bitCnt <= '0;
            busy   <= 1'b1;
            state  <= CONVERT;
          end
        end

        CONVERT: begin
          bcd <= stepBcd;
          mag <= stepMag;
          if (bitCnt == CNT_W'(WIDTH - 1)) begin
            // Sign column does not depend on the BCD value still being written.
            bitCnt    <= '0;
            charIdx   <= '0;
            charOut   <= charTable[0];
            charValid <= 1'b1;
            state     <= EMIT;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end

        EMIT: begin
          if (charReady) begin
            if (charIdx == IDX_W'(DIGITS)) begin
              charIdx   <= '0;
              charOut   <= ASCII_SPACE;
              charValid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              charIdx <= charIdx + 1'b1;
              charOut <= charTable[charIdx + 1'b1];
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : lcd_dec_formatter

// File: tb/tb_lcd_dec_formatter.sv
// -----------------------------------------------------------------------------
// tb_lcd_dec_formatter
//   Scoreboard bench: the driver pushes the expected character stream for each
//   job into expQ; the monitor pops and compares on every handshake. A second
//   instance with BLANK_ZEROS=0 covers the unblanked layout.
// -----------------------------------------------------------------------------
module tb_lcd_dec_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] dataIn;
  logic        signedMode;
  logic [7:0]  charOut;
  logic        charValid;
  logic        charReady;
  logic        busy;
  logic        done;

  logic        zStart;
  logic [17:0] zDataIn;
  logic        zSignedMode;
  logic [7:0]  zCharOut;
  logic        zCharValid;
  logic        zCharReady;
  logic        zBusy;
  logic        zDone;

  logic [7:0] expQ [$];
  int passCnt   = 0;
  int totalCnt  = 0;
  int doneSeen  = 0;
  int expDone   = 0;
  int acceptCnt = 0;

  always #5 clk = ~clk;

  lcd_dec_formatter #(.WIDTH(18), .DIGITS(6), .BLANK_ZEROS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dataIn     (dataIn),
    .signedMode (signedMode),
    .charOut    (charOut),
    .charValid  (charValid),
    .charReady  (charReady),
    .busy       (busy),
    .done       (done)
  );

  lcd_dec_formatter #(.WIDTH(18), .DIGITS(6), .BLANK_ZEROS(0)) dutZ (
    .clk        (clk),
    .rst        (rst),
    .start      (zStart),
    .dataIn     (zDataIn),
    .signedMode (zSignedMode),
    .charOut    (zCharOut),
    .charValid  (zCharValid),
    .charReady  (zCharReady),
    .busy       (zBusy),
    .done       (zDone)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every accepted character against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (charValid && charReady) begin
        acceptCnt++;
        if (expQ.size() == 0) begin
          check("unexpected_char", {24'd0, charOut}, 32'hFFFF_FFFF);
        end else begin
          check("char", {24'd0, charOut}, {24'd0, expQ.pop_front()});
        end
      end
      if (done) doneSeen++;
    end
  end

  task automatic pushExp(input string s);
    for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
  endtask

  // Returns just after edge N (the edge that accepted start).
  task automatic doStart(input logic [17:0] d, input logic sm, input string s);
    pushExp(s);
    acceptCnt = 0;
    @(posedge clk); #1;
    start = 1'b1; dataIn = d; signedMode = sm;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 200);
    if (busy) check({name, "_timeout"}, 32'd1, 32'd0);
    expDone++;
    check({name, "_done_count"}, doneSeen, expDone);
    check({name, "_queue_empty"}, expQ.size(), 0);
  endtask

  task automatic waitAccepts(input int target);
    int n = 0;
    while (acceptCnt < target && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (acceptCnt < target) check("accept_timeout", acceptCnt, target);
  endtask

  task automatic runJob(input logic [17:0] d, input logic sm, input string s, input string name);
    doStart(d, sm, s);
    waitIdle(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    int firstV;
    int doneE;
    int k;
    int n;
    string zs;

    rst = 1'b1; start = 1'b0; dataIn = '0; signedMode = 1'b0; charReady = 1'b1;
    zStart = 1'b0; zDataIn = '0; zSignedMode = 1'b0; zCharReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_charOut", {24'd0, charOut}, 32'h20);
    check("rst_charValid", charValid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // First job with latency measurement from edge N.
    doStart(18'd12345, 1'b0, "  12345");
    check("busy_after_start", busy, 1);
    e = 0; firstV = -1; doneE = -1;
    while (e < 60 && doneE < 0) begin
      @(posedge clk); e++;
      @(negedge clk);
      if (charValid && firstV < 0) firstV = e;
      if (done) doneE = e;
    end
    check("first_valid_latency", firstV, 18);
    check("done_latency", doneE, 25);
    @(posedge clk); @(negedge clk);
    check("done_one_cycle", done, 0);
    waitIdle("u12345");

    runJob(18'd0,      1'b0, "      0", "u0");
    runJob(18'd262143, 1'b0, " 262143", "u262143");
    runJob(18'h3FFFF,  1'b1, "-     1", "s_minus1");
    runJob(18'h20000,  1'b1, "-131072", "s_min");
    runJob(18'h1FFFF,  1'b1, " 131071", "s_max");
    runJob(18'h3FFFF,  1'b0, " 262143", "u_allones");

    // Backpressure on index 2 ('2' of "  23456").
    doStart(18'd23456, 1'b0, "  23456");
    waitAccepts(2);
    charReady = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_charOut", {24'd0, charOut}, 32'h32);
      check("bp_charValid", charValid, 1);
    end
    check("bp_no_advance", acceptCnt, 2);
    @(posedge clk); #1;
    charReady = 1'b1;
    waitIdle("backpressure");

    // start during CONVERT and EMIT must be ignored.
    doStart(18'd777, 1'b0, "    777");
    repeat (5) @(posedge clk);
    #1; start = 1'b1; dataIn = 18'd99999;
    @(posedge clk); #1; start = 1'b0;
    waitAccepts(1);
    start = 1'b1; dataIn = 18'd54321;
    @(posedge clk); #1; start = 1'b0;
    waitIdle("ignore_start");
    repeat (3) @(posedge clk);
    #1;
    check("no_queued_job", busy, 0);

    // Reset mid-EMIT after three accepts.
    doStart(18'd12345, 1'b0, "  12345");
    waitAccepts(3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_charValid", charValid, 0);
    check("abort_busy", busy, 0);
    check("abort_charOut", {24'd0, charOut}, 32'h20);
    check("abort_done", done, 0);
    expQ.delete();
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", doneSeen, expDone);
    check("abort_idle_valid", charValid, 0);
    runJob(18'h3FF9C, 1'b1, "-   100", "after_abort");

    // BLANK_ZEROS=0 instance.
    zs = " 000042";
    @(posedge clk); #1;
    zStart = 1'b1; zDataIn = 18'd42; zSignedMode = 1'b0;
    @(posedge clk); #1;
    zStart = 1'b0;
    k = 0; n = 0;
    while (n < 100 && !zDone) begin
      @(negedge clk); n++;
      if (zCharValid && zCharReady) begin
        if (k < 7) check("z_char", {24'd0, zCharOut}, {24'd0, zs[k]});
        k++;
      end
    end
    check("z_done_seen", zDone, 1);
    check("z_char_count", k, 7);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule : tb_lcd_dec_formatter
